// File: rtl/note_phase_acc.sv
// note_phase_acc
//   Turns a MIDI note number into a DDS phase increment and runs the phase
//   accumulator that feeds the sine-table stage.
//   The increment comes from a 12-entry table for the top octave (notes
//   120..131). Each lower octave halves it, so it is shifted right once for
//   every octave below 10.
//
// Ports
//   CLK        in   1  clock; all state changes on its rising edge
//   RESET      in   1  asynchronous, active-low reset
//   NOTE       in   8  MIDI note number, sampled on acceptance
//   NOTE_VALID in   1  request to load NOTE
//   READY      out  1  high when a note can be accepted (FSM idle)
//   ENABLE     in   1  accumulator advance enable
//   PHASE_RST  in   1  synchronous clear of the phase (has priority over ENABLE)
//   ADDER      out 32  current phase increment
//   DDS        out 32  phase accumulator
//   WRAP       out  1  one-cycle pulse after the accumulator carries out of bit 31
//   NOTE_ERR   out  1  one-cycle pulse after a note above 127 is rejected
module note_phase_acc #(
    parameter int unsigned F_CLK_HZ = 10000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  NOTE,
    input  logic        NOTE_VALID,
    output logic        READY,
    input  logic        ENABLE,
    input  logic        PHASE_RST,
    output logic [31:0] ADDER,
    output logic [31:0] DDS,
    output logic        WRAP,
    output logic        NOTE_ERR
);

    // The table below is only valid for a 10 MHz clock. Any other rate
    // yields a zero increment, which holds the phase still.
    localparam bit CLK_SUPPORTED = (F_CLK_HZ == 32'd10000000);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_rem;
    logic [3:0]  r_oct;
    logic [31:0] r_adder;
    logic [31:0] r_dds;
    logic        r_wrap;
    logic        r_err;
    logic [31:0] w_tbl_raw;
    logic [31:0] w_tbl;
    logic [3:0]  w_shift;
    logic [32:0] w_sum;

    // Increments for notes 120..131, indexed by semitone within the octave.
    always_comb begin
        w_tbl_raw = '0;
        case (r_rem)
            8'd0:    w_tbl_raw = 32'd3595754;
            8'd1:    w_tbl_raw = 32'd3809569;
            8'd2:    w_tbl_raw = 32'd4036098;
            8'd3:    w_tbl_raw = 32'd4276097;
            8'd4:    w_tbl_raw = 32'd4530367;
            8'd5:    w_tbl_raw = 32'd4799756;
            8'd6:    w_tbl_raw = 32'd5085165;
            8'd7:    w_tbl_raw = 32'd5387544;
            8'd8:    w_tbl_raw = 32'd5707904;
            8'd9:    w_tbl_raw = 32'd6047114;
            8'd10:   w_tbl_raw = 32'd6406906;
            8'd11:   w_tbl_raw = 32'd6787880;
            default: w_tbl_raw = '0;
        endcase
    end

    assign w_tbl   = CLK_SUPPORTED ? w_tbl_raw : '0;
    assign w_shift = 4'd10 - r_oct;

    // ---------------- FSM state register ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (NOTE_VALID && (NOTE <= 8'd127)) begin
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (r_rem < 8'd12) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The note is split into octave and semitone by repeated subtraction of 12,
    // one step per cycle, so no divider is needed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rem   <= '0;
            r_oct   <= '0;
            r_adder <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (NOTE_VALID) begin
                        if (NOTE > 8'd127) begin
                            r_err <= 1'b1;
                        end else begin
                            r_rem <= NOTE;
                            r_oct <= '0;
                        end
                    end
                end
                DIV: begin
                    if (r_rem >= 8'd12) begin
                        r_rem <= r_rem - 8'd12;
                        r_oct <= r_oct + 4'd1;
                    end
                end
                LOAD: begin
                    r_adder <= w_tbl >> w_shift;
                end
                default: ;
            endcase
        end
    end

    // ---------------- phase accumulator ----------------
    assign w_sum = {1'b0, r_dds} + {1'b0, r_adder};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_dds  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (PHASE_RST) begin
                r_dds  <= '0;
                r_wrap <= 1'b0;
            end else if (ENABLE) begin
                r_dds  <= w_sum[31:0];
                r_wrap <= w_sum[32];
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign READY    = (r_state == IDLE);
    assign ADDER    = r_adder;
    assign DDS      = r_dds;
    assign WRAP     = r_wrap;
    assign NOTE_ERR = r_err;

endmodule
